trigger_sequencer: RTL
======================

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter pNUM_TRIG, default 8, number of synchronous trigger sources (match rules).
REQ-002 SHALL have parameter pDELAY_WIDTH, default 16, width of the trigger delay counter.
REQ-003 SHALL have parameter pPULSE_WIDTH, default 16, width of the output pulse-length counter.
REQ-004 SHALL have parameter pCOUNT_WIDTH, default 16, width of the trigger event counter.
REQ-005 SHALL have one clock and a synchronous, active-high reset: trace_clk (input, 1) and reset (input, 1).
REQ-006 SHALL have I_trig_async, input, 1, target trigger pin, asynchronous to trace_clk.
REQ-007 SHALL have I_trig_sync, input, pNUM_TRIG, match-rule pulses, synchronous to trace_clk.
REQ-008 SHALL have I_enable_mask, input, pNUM_TRIG+1; bit 0 is I_trig_async and bit i+1 is I_trig_sync[i].
REQ-009 SHALL have I_combine_and, input, 1; 0 ORs the enabled sources and 1 ANDs them.
REQ-010 SHALL have I_continuous, input, 1; 0 is one-shot and 1 re-arms after each pulse.
REQ-011 SHALL have I_arm and I_disarm, inputs, 1 each, single-cycle command strobes.
REQ-012 SHALL have I_delay (input, pDELAY_WIDTH) and I_pulse_len (input, pPULSE_WIDTH), both in trace_clk cycles.
REQ-013 SHALL have O_trig_out (output, 1), registered trigger pulse.
REQ-014 SHALL have O_armed and O_busy, outputs, 1 each, state flags.
REQ-015 SHALL have O_trig_count, output, pCOUNT_WIDTH, count of pulses issued.

Function
REQ-016 SHALL pass I_trig_async through a 2-FF synchronizer before masking.
REQ-017 SHALL register the combined condition (cond_r) once per cycle; an all-zero mask makes cond false in both OR and AND modes.
REQ-018 SHALL define a trigger event as a cond rising edge (cond_r high, previous cond_r low) detected in ARMED; a held-high condition yields one event.
REQ-019 SHALL implement states IDLE, ARMED, DELAY, PULSE.
REQ-020 SHALL go IDLE->ARMED on I_arm, clearing O_trig_count at the same time.
REQ-021 SHALL go ARMED->DELAY on an event when I_delay>0, and ARMED->PULSE when I_delay=0.
REQ-022 SHALL stay in DELAY exactly I_delay cycles, then go to PULSE.
REQ-023 SHALL stay in PULSE for max(I_pulse_len,1) cycles, then go to ARMED if I_continuous=1, else IDLE.
REQ-024 SHALL raise O_trig_out at clock edge k+2+I_delay for an I_trig_sync edge sampled at edge k, and at edge k+4+I_delay for an I_trig_async edge.
REQ-025 SHALL drive O_trig_out high only in PULSE; O_armed high only in ARMED; O_busy high in DELAY or PULSE.
REQ-026 SHALL increment O_trig_count on each PULSE entry and saturate at all-ones.
REQ-027 SHALL ignore events in DELAY/PULSE, with no queueing.
REQ-028 SHALL ignore I_arm outside IDLE.
REQ-029 SHALL go to IDLE from any state on I_disarm, with O_trig_out low the next cycle and O_trig_count retained.
REQ-030 SHALL let I_disarm win over a simultaneous I_arm.
REQ-031 SHALL sample I_delay, I_pulse_len, I_continuous and the mask on the event cycle; changes afterwards do not affect the pulse in flight.
REQ-032 SHALL require that a continuous re-arm with cond_r still high produces no event until cond_r falls and rises again.

Reset
REQ-033 SHALL on reset go to IDLE and clear O_trig_out, O_armed, O_busy, O_trig_count, the synchronizer flops and cond_r (0), including when reset is asserted mid-DELAY or mid-PULSE.

Structure
REQ-034 SHALL keep state encodings (IDLE=0, ARMED=1, DELAY=2, PULSE=3) in the shared trigger defines include file.
REQ-035 SHALL use a single sub-module, sync_2ff, for I_trig_async.

Verification
REQ-036 SHALL cover a one-shot OR test: mask=0x002, delay=5, len=3, I_trig_sync[0] pulse at edge 10 -> O_trig_out high on edges 17-19, count=1, then IDLE.
REQ-037 SHALL cover a continuous AND test: mask=0x006, src0 held high, src1 pulses at edges 20 and 40, delay=0, len=1 -> pulses at edges 22 and 42, count=2, and O_armed high between them.
REQ-038 SHALL cover an async test: mask=0x001, I_trig_async rises at edge 30, delay=0, len=0 -> single one-cycle pulse at edge 34.
REQ-039 SHALL cover an abort test: delay=100, then disarm 10 cycles after the event -> no pulse and IDLE next cycle; same with reset -> count=0.
REQ-040 SHALL cover ignore and saturation: a second event during DELAY -> only one pulse; pCOUNT_WIDTH=2 with 5 continuous events -> count=3.

Source files
------------

// File: rtl/trigger_sequencer_pkg.sv
// Shared definitions for the trigger sequencer: FSM state encoding and
// synchronizer depth.
package trigger_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } trig_state_t;

    localparam int SYNC_STAGES = 2;

endpackage : trigger_sequencer_pkg

// File: rtl/trigger_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous trigger pin into the
// trace clock domain; both stages clear on synchronous reset.
module sync_2ff
    import trigger_sequencer_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/trigger_sequencer.sv
// Trigger sequencer: combines masked trigger sources, detects a rising edge of
// the combined condition while armed, then waits a delay and emits a pulse.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int pNUM_TRIG    = 8,
    parameter int pDELAY_WIDTH = 16,
    parameter int pPULSE_WIDTH = 16,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    trace_clk,
    input  logic                    reset,
    input  logic                    I_trig_async,
    input  logic [pNUM_TRIG-1:0]    I_trig_sync,
    input  logic [pNUM_TRIG:0]      I_enable_mask,
    input  logic                    I_combine_and,
    input  logic                    I_continuous,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pPULSE_WIDTH-1:0] I_pulse_len,
    output logic                    O_trig_out,
    output logic                    O_armed,
    output logic                    O_busy,
    output logic [pCOUNT_WIDTH-1:0] O_trig_count
);

    localparam logic [pDELAY_WIDTH-1:0] DELAY_ONE = 1;
    localparam logic [pPULSE_WIDTH-1:0] PULSE_ONE = 1;
    localparam logic [pCOUNT_WIDTH-1:0] COUNT_ONE = 1;

    logic                    w_async_sync;
    logic [pNUM_TRIG:0]      w_sources;
    logic [pNUM_TRIG:0]      w_or_terms;
    logic [pNUM_TRIG:0]      w_and_terms;
    logic                    w_cond;

    logic                    r_cond;
    logic                    r_cond_prev;
    logic                    r_event;

    trig_state_t             r_state;
    trig_state_t             w_state_next;
    logic                    w_event_take;
    logic                    w_pulse_entry;
    logic [pPULSE_WIDTH-1:0] w_len_src;

    logic [pDELAY_WIDTH-1:0] r_delay_cnt;
    logic [pPULSE_WIDTH-1:0] r_pulse_cnt;
    logic [pPULSE_WIDTH-1:0] r_pulse_len;
    logic                    r_continuous;
    logic [pCOUNT_WIDTH-1:0] r_trig_count;
    logic                    r_trig_out;
    logic                    r_armed;
    logic                    r_busy;

    sync_2ff u_sync_2ff (
        .clk  (trace_clk),
        .srst (reset),
        .i_d  (I_trig_async),
        .o_q  (w_async_sync)
    );

    // Source vector index matches mask bit: bit 0 async, bit i+1 sync[i].
    assign w_sources = {I_trig_sync, w_async_sync};

    generate
        for (genvar gi = 0; gi <= pNUM_TRIG; gi++) begin : g_src
            assign w_or_terms[gi]  = w_sources[gi] & I_enable_mask[gi];
            assign w_and_terms[gi] = w_sources[gi] | ~I_enable_mask[gi];
        end
    endgenerate

    // An empty mask must never fire, even though the AND reduction would be 1.
    assign w_cond = (|I_enable_mask) &
                    (I_combine_and ? (&w_and_terms) : (|w_or_terms));

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_cond      <= 1'b0;
            r_cond_prev <= 1'b0;
            r_event     <= 1'b0;
        end else begin
            r_cond      <= w_cond;
            r_cond_prev <= r_cond;
            r_event     <= r_cond & ~r_cond_prev;
        end
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_arm) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (r_event) begin
                    w_state_next = (I_delay != '0) ? ST_DELAY : ST_PULSE;
                end
            end
            ST_DELAY: begin
                if (r_delay_cnt == '0) begin
                    w_state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_pulse_cnt == '0) begin
                    w_state_next = r_continuous ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (I_disarm) begin
            w_state_next = ST_IDLE;
        end
    end

    assign w_event_take  = (r_state == ST_ARMED) & r_event & ~I_disarm;
    assign w_pulse_entry = (w_state_next == ST_PULSE) & (r_state != ST_PULSE);
    // A zero-delay event enters PULSE straight from ARMED using the live length.
    assign w_len_src     = (r_state == ST_ARMED) ? I_pulse_len : r_pulse_len;

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_delay_cnt  <= '0;
            r_pulse_cnt  <= '0;
            r_pulse_len  <= '0;
            r_continuous <= 1'b0;
        end else begin
            if (w_event_take) begin
                r_delay_cnt  <= I_delay - DELAY_ONE;
                r_pulse_len  <= I_pulse_len;
                r_continuous <= I_continuous;
            end else if ((r_state == ST_DELAY) && (r_delay_cnt != '0)) begin
                r_delay_cnt <= r_delay_cnt - DELAY_ONE;
            end

            if (w_pulse_entry) begin
                r_pulse_cnt <= (w_len_src == '0) ? '0 : (w_len_src - PULSE_ONE);
            end else if ((r_state == ST_PULSE) && (r_pulse_cnt != '0)) begin
                r_pulse_cnt <= r_pulse_cnt - PULSE_ONE;
            end
        end
    end

    // Flags are registered from the next state so they line up with r_state.
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_trig_count <= '0;
            r_trig_out   <= 1'b0;
            r_armed      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && I_arm && !I_disarm) begin
                r_trig_count <= '0;
            end else if (w_pulse_entry && (r_trig_count != '1)) begin
                r_trig_count <= r_trig_count + COUNT_ONE;
            end
            r_trig_out <= (w_state_next == ST_PULSE);
            r_armed    <= (w_state_next == ST_ARMED);
            r_busy     <= (w_state_next == ST_DELAY) || (w_state_next == ST_PULSE);
        end
    end

    assign O_trig_out   = r_trig_out;
    assign O_armed      = r_armed;
    assign O_busy       = r_busy;
    assign O_trig_count = r_trig_count;

endmodule : trigger_sequencer
